// File: rtl/adc_sar_scan_ctrl.sv
// adc_sar_scan_ctrl: multi-channel SAR ADC scan sequencer (mask walk, mux settle, SOC/EOC handshake).
// Build macro ADC_SAR_SCAN_AVG_EN: convert each channel four times and report the truncated mean.
module adc_sar_scan_ctrl #(
  parameter int N    = 8,
  parameter int NCH  = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           enable,
  input  logic           start,
  input  logic           continuous,
  input  logic [NCH-1:0] ch_mask,
  input  logic [3:0]     settle_cycles,
  output logic [CHW-1:0] mux_sel,
  output logic           adc_soc,
  input  logic           adc_eoc,
  input  logic [N-1:0]   adc_dout,
  output logic           busy,
  output logic           res_valid,
  output logic [CHW-1:0] res_ch,
  output logic [N-1:0]   res_data,
  output logic           scan_done
);

  typedef enum logic [2:0] {IDLE, SETTLE, SOC, WAIT_BUSY, WAIT_EOC, NEXT} state_t;

  state_t         state_reg, state_next;
  logic [NCH-1:0] mask_reg, mask_next;
  logic [CHW-1:0] mux_sel_reg, mux_sel_next;
  logic [3:0]     settle_cnt_reg, settle_cnt_next;
  logic [CHW-1:0] res_ch_reg, res_ch_next;
  logic [N-1:0]   res_data_reg, res_data_next;
  logic [NCH-1:0] above_sel;
  logic [CHW-1:0] next_ch;
  logic [CHW-1:0] first_live_ch;
  logic           has_next;

`ifdef ADC_SAR_SCAN_AVG_EN
  logic [N+1:0] acc_reg, acc_next, acc_sum;
  logic [1:0]   conv_cnt_reg, conv_cnt_next;

  assign acc_sum = acc_reg + {2'b00, adc_dout};
`endif

  function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CHW'(i);
    end
  endfunction

  // Channels still pending in this scan: set in the latched mask and above the current one.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_above
      assign above_sel[gi] = mask_reg[gi] && (CHW'(gi) > mux_sel_reg);
    end
  endgenerate

  assign has_next      = |above_sel;
  assign next_ch       = lowest_set(above_sel);
  assign first_live_ch = lowest_set(ch_mask);

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    mux_sel_next    = mux_sel_reg;
    settle_cnt_next = settle_cnt_reg;
    res_ch_next     = res_ch_reg;
    res_data_next   = res_data_reg;
`ifdef ADC_SAR_SCAN_AVG_EN
    acc_next        = acc_reg;
    conv_cnt_next   = conv_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start && enable && (ch_mask != '0)) begin
          mask_next       = ch_mask;
          mux_sel_next    = first_live_ch;
          settle_cnt_next = settle_cycles;
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
`ifdef ADC_SAR_SCAN_AVG_EN
        acc_next      = '0;
        conv_cnt_next = '0;
`endif
        if (!enable)                      state_next = IDLE;
        else if (settle_cnt_reg == 4'd0)  state_next = SOC;
        else                              settle_cnt_next = settle_cnt_reg - 4'd1;
      end
      // Once the pulse is out the conversion must be allowed to finish, even if disabled.
      SOC: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!adc_eoc) state_next = WAIT_EOC;
      end
      WAIT_EOC: begin
        if (adc_eoc) begin
          if (!enable) begin
            state_next = IDLE;
          end else begin
`ifdef ADC_SAR_SCAN_AVG_EN
            if (conv_cnt_reg != 2'd3) begin
              acc_next      = acc_sum;
              conv_cnt_next = conv_cnt_reg + 2'd1;
              state_next    = SOC;
            end else begin
              res_data_next = acc_sum[N+1:2];
              res_ch_next   = mux_sel_reg;
              state_next    = NEXT;
            end
`else
            res_data_next = adc_dout;
            res_ch_next   = mux_sel_reg;
            state_next    = NEXT;
`endif
          end
        end
      end
      NEXT: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (has_next) begin
          mux_sel_next    = next_ch;
          settle_cnt_next = settle_cycles;
          state_next      = SETTLE;
        end else if (continuous && (ch_mask != '0)) begin
          mask_next       = ch_mask;
          mux_sel_next    = first_live_ch;
          settle_cnt_next = settle_cycles;
          state_next      = SETTLE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_reg      <= IDLE;
      mask_reg       <= '0;
      mux_sel_reg    <= '0;
      settle_cnt_reg <= '0;
      res_ch_reg     <= '0;
      res_data_reg   <= '0;
`ifdef ADC_SAR_SCAN_AVG_EN
      acc_reg        <= '0;
      conv_cnt_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      mux_sel_reg    <= mux_sel_next;
      settle_cnt_reg <= settle_cnt_next;
      res_ch_reg     <= res_ch_next;
      res_data_reg   <= res_data_next;
`ifdef ADC_SAR_SCAN_AVG_EN
      acc_reg        <= acc_next;
      conv_cnt_reg   <= conv_cnt_next;
`endif
    end
  end

  assign mux_sel   = mux_sel_reg;
  assign adc_soc   = (state_reg == SOC);
  assign busy      = (state_reg != IDLE);
  assign res_valid = (state_reg == NEXT);
  assign scan_done = (state_reg == NEXT) && !has_next;
  assign res_ch    = res_ch_reg;
  assign res_data  = res_data_reg;

endmodule

// File: tb/tb_adc_sar_scan_ctrl.sv
// Self-checking bench for adc_sar_scan_ctrl: behavioural ADC, strobe monitor and scenario tasks.
`timescale 1ns/1ps
module tb_adc_sar_scan_ctrl;
  localparam int N   = 8;
  localparam int NCH = 4;
  localparam int CHW = 2;
`ifdef ADC_SAR_SCAN_AVG_EN
  localparam int K = 4;
`else
  localparam int K = 1;
`endif

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           enable = 1'b0;
  logic           start = 1'b0;
  logic           continuous = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [3:0]     settle_cycles = '0;
  logic [CHW-1:0] mux_sel;
  logic           adc_soc;
  logic           adc_eoc = 1'b1;
  logic [N-1:0]   adc_dout = '0;
  logic           busy;
  logic           res_valid;
  logic [CHW-1:0] res_ch;
  logic [N-1:0]   res_data;
  logic           scan_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_ch[$];
  int st_data[$];
  int st_done[$];
  int st_exp[$];
  int soc_cyc[$];
  int hist_val[$];
  int fixed_q[$];
  int mux_err = 0;
  int mux_seen = 0;
  int sd_cnt = 0;
  int busy_cnt = 0;
  int conv_ch = 0;
  int adc_mode = 0;

  adc_sar_scan_ctrl #(.N(N), .NCH(NCH)) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .settle_cycles(settle_cycles), .mux_sel(mux_sel), .adc_soc(adc_soc),
    .adc_eoc(adc_eoc), .adc_dout(adc_dout), .busy(busy), .res_valid(res_valid),
    .res_ch(res_ch), .res_data(res_data), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // ADC: goes busy 1-2 cycles after soc, converts for 2-4 cycles, then presents its result.
  initial begin : adc_model
    int d;
    int v;
    int ch;
    forever begin
      @(negedge clk);
      if (adc_soc === 1'b1) begin
        ch = int'(mux_sel);
        conv_ch = ch;
        d = $urandom_range(1, 2);
        repeat (d) @(negedge clk);
        adc_eoc = 1'b0;
        adc_dout = N'($urandom);
        d = $urandom_range(2, 4);
        repeat (d) @(negedge clk);
        if (fixed_q.size() > 0)  v = fixed_q.pop_front();
        else if (adc_mode == 1)  v = (ch == 1) ? 'hA5 : 0;
        else                     v = int'($urandom_range(0, 255));
        adc_dout = N'(v);
        adc_eoc = 1'b1;
        hist_val.push_back(v);
      end
    end
  end

  // Logs every strobe with the value the ADC model says it must carry (mean of last K results).
  initial begin : monitor
    int s;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (adc_soc === 1'b1) soc_cyc.push_back(cyc);
      if (busy === 1'b1) begin
        busy_cnt++;
        mux_seen = mux_seen | (1 << int'(mux_sel));
        if (adc_eoc === 1'b0 && int'(mux_sel) != conv_ch) mux_err++;
      end
      if (scan_done === 1'b1) sd_cnt++;
      if (res_valid === 1'b1) begin
        s = 0;
        if (hist_val.size() >= K) begin
          for (int i = 0; i < K; i++) s += hist_val[hist_val.size() - 1 - i];
          s = s / K;
        end else begin
          s = -1;
        end
        st_ch.push_back(int'(res_ch));
        st_data.push_back(int'(res_data));
        st_done.push_back(scan_done === 1'b1 ? 1 : 0);
        st_exp.push_back(s);
        $display("strobe cyc=%0d ch=%0d data=%0d done=%0b model_data=%0d", cyc, res_ch, res_data, scan_done, s);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    st_ch.delete(); st_data.delete(); st_done.delete(); st_exp.delete(); soc_cyc.delete();
    mux_err = 0; mux_seen = 0; sd_cnt = 0; busy_cnt = 0;
  endtask

  task automatic pulse_start(input logic [3:0] m, input logic [3:0] s, input logic c, output int t0);
    @(negedge clk);
    ch_mask = m; settle_cycles = s; continuous = c; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    @(negedge clk);
    while (busy !== 1'b0) begin
      if (n >= budget) begin to = 1'b1; break; end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mux_sel !== '0) begin errors++; $display("FAIL reset_mux_sel got %0d want 0", mux_sel); end
    checks++; if (busy !== 1'b0 || adc_soc !== 1'b0) begin errors++; $display("FAIL reset_busy_soc got %b%b want 00", busy, adc_soc); end
    checks++; if (res_valid !== 1'b0 || scan_done !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b want 00", res_valid, scan_done); end
    checks++; if (res_ch !== '0 || res_data !== '0) begin errors++; $display("FAIL reset_result got ch=%0d data=%0d want 0/0", res_ch, res_data); end
    rstb = 1'b1; enable = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_mask_scans();
    logic [3:0] m;
    logic [3:0] s;
    int t0;
    bit to;
    int exp_ch[$];
    for (int it = 0; it < 8; it++) begin
      m = (it == 0) ? 4'b1011 : 4'($urandom_range(1, 15));
      s = (it == 0) ? 4'd2 : 4'($urandom_range(0, 15));
      exp_ch.delete();
      for (int b = 0; b < NCH; b++) if (m[b]) exp_ch.push_back(b);
      clear_logs();
      pulse_start(m, s, 1'b0, t0);
      repeat (3) @(negedge clk);
      ch_mask = 4'b1111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(3000, to);
      checks++; if (to) begin errors++; $display("FAIL scan_timeout it=%0d busy still %b want 0", it, busy); end
      checks++;
      if (st_ch.size() != exp_ch.size()) begin
        errors++; $display("FAIL scan_strobe_count it=%0d got %0d want %0d", it, st_ch.size(), exp_ch.size());
      end else begin
        for (int i = 0; i < exp_ch.size(); i++) begin
          checks++; if (st_ch[i] != exp_ch[i]) begin errors++; $display("FAIL scan_ch it=%0d idx=%0d got %0d want %0d", it, i, st_ch[i], exp_ch[i]); end
          checks++; if (st_data[i] != st_exp[i]) begin errors++; $display("FAIL scan_data it=%0d idx=%0d got %0d want %0d", it, i, st_data[i], st_exp[i]); end
          checks++; if (st_done[i] != ((i == exp_ch.size() - 1) ? 1 : 0)) begin errors++; $display("FAIL scan_done_pos it=%0d idx=%0d got %0d", it, i, st_done[i]); end
        end
        checks++; if (res_ch !== CHW'(exp_ch[exp_ch.size() - 1]) || int'(res_data) != st_exp[st_exp.size() - 1]) begin
          errors++; $display("FAIL scan_hold it=%0d got ch=%0d data=%0d", it, res_ch, res_data);
        end
      end
      checks++; if (soc_cyc.size() != exp_ch.size() * K) begin errors++; $display("FAIL scan_soc_count it=%0d got %0d want %0d", it, soc_cyc.size(), exp_ch.size() * K); end
      checks++; if (soc_cyc.size() == 0 || soc_cyc[0] != t0 + int'(s) + 2) begin
        errors++; $display("FAIL scan_soc_latency it=%0d got %0d want %0d", it, (soc_cyc.size() > 0) ? soc_cyc[0] - t0 : -1, int'(s) + 2);
      end
      checks++; if (mux_err != 0 || sd_cnt != 1) begin errors++; $display("FAIL scan_mux_or_done it=%0d got mux_err=%0d done_pulses=%0d want 0/1", it, mux_err, sd_cnt); end
      $display("scan it=%0d mask=%b settle=%0d strobes=%0d", it, m, s, st_ch.size());
    end
  endtask

  task automatic test_single_ch1();
    int t0;
    bit to;
    adc_mode = 1;
    clear_logs();
    pulse_start(4'b0010, 4'd0, 1'b0, t0);
    wait_idle(500, to);
    checks++; if (to) begin errors++; $display("FAIL ch1_timeout busy %b want 0", busy); end
    checks++; if (soc_cyc.size() == 0 || soc_cyc[0] != t0 + 2) begin errors++; $display("FAIL ch1_soc_latency got %0d want 2", (soc_cyc.size() > 0) ? soc_cyc[0] - t0 : -1); end
    checks++; if (st_ch.size() != 1) begin errors++; $display("FAIL ch1_strobe_count got %0d want 1", st_ch.size()); end
    else begin
      checks++; if (st_ch[0] != 1 || st_data[0] != 'hA5) begin errors++; $display("FAIL ch1_result got ch=%0d data=%0h want 1/a5", st_ch[0], st_data[0]); end
    end
    checks++; if (mux_seen != 2) begin errors++; $display("FAIL ch1_mux_sel seen mask %b want 0010", mux_seen[3:0]); end
    adc_mode = 0;
    $display("test_single_ch1 done");
  endtask

  task automatic test_continuous();
    int t0;
    int n;
    bit to;
    int exp_ch[4] = '{0, 2, 1, 2};
    int exp_dn[4] = '{0, 1, 0, 1};
    clear_logs();
    pulse_start(4'b0101, 4'($urandom_range(0, 3)), 1'b1, t0);
    ch_mask = 4'b0110;
    n = 0;
    while (st_ch.size() < 3 && n < 2000) begin @(negedge clk); n++; end
    continuous = 1'b0;
    wait_idle(2000, to);
    checks++; if (to || n >= 2000) begin errors++; $display("FAIL cont_timeout got n=%0d busy=%b", n, busy); end
    checks++; if (st_ch.size() != 4) begin errors++; $display("FAIL cont_strobe_count got %0d want 4", st_ch.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (st_ch[i] != exp_ch[i] || st_done[i] != exp_dn[i] || st_data[i] != st_exp[i]) begin
          errors++; $display("FAIL cont_strobe idx=%0d got ch=%0d done=%0d data=%0d want ch=%0d done=%0d data=%0d",
                             i, st_ch[i], st_done[i], st_data[i], exp_ch[i], exp_dn[i], st_exp[i]);
        end
      end
    end
    $display("test_continuous strobes=%0d", st_ch.size());
  endtask

  task automatic test_reset_mid();
    int t0;
    int n;
    bit to;
    clear_logs();
    pulse_start(4'b1111, 4'd1, 1'b0, t0);
    n = 0;
    while (adc_eoc !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    checks++; if (n >= 200) begin errors++; $display("FAIL rmid_no_conversion got n=%0d", n); end
    checks++; if (busy !== 1'b0 || adc_soc !== 1'b0 || res_valid !== 1'b0 || scan_done !== 1'b0) begin
      errors++; $display("FAIL rmid_ctrl got busy=%b soc=%b valid=%b done=%b want 0000", busy, adc_soc, res_valid, scan_done);
    end
    checks++; if (mux_sel !== '0 || res_ch !== '0 || res_data !== '0) begin
      errors++; $display("FAIL rmid_regs got mux=%0d ch=%0d data=%0d want 0", mux_sel, res_ch, res_data);
    end
    rstb = 1'b1;
    n = 0;
    while (adc_eoc !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++; if (st_ch.size() != 0) begin errors++; $display("FAIL rmid_strobe got %0d strobes want 0", st_ch.size()); end
    clear_logs();
    pulse_start(4'b0100, 4'd0, 1'b0, t0);
    wait_idle(500, to);
    checks++; if (to || st_ch.size() != 1) begin errors++; $display("FAIL rmid_restart got to=%0d strobes=%0d want 0/1", to, st_ch.size()); end
    else begin
      checks++; if (st_ch[0] != 2 || st_data[0] != st_exp[0]) begin errors++; $display("FAIL rmid_restart_result got ch=%0d data=%0d want 2/%0d", st_ch[0], st_data[0], st_exp[0]); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_disable();
    int t0;
    int n;
    bit to;
    clear_logs();
    pulse_start(4'b0011, 4'd0, 1'b0, t0);
    n = 0;
    while (soc_cyc.size() < 1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    enable = 1'b0;
    wait_idle(500, to);
    checks++; if (to || n >= 200) begin errors++; $display("FAIL dis_timeout got n=%0d busy=%b", n, busy); end
    checks++; if (adc_eoc !== 1'b1) begin errors++; $display("FAIL dis_idle_eoc got %b want 1", adc_eoc); end
    checks++; if (soc_cyc.size() != 1 || st_ch.size() != 0 || sd_cnt != 0) begin
      errors++; $display("FAIL dis_activity got soc=%0d strobes=%0d done=%0d want 1/0/0", soc_cyc.size(), st_ch.size(), sd_cnt);
    end
    repeat (5) @(negedge clk);
    clear_logs();
    pulse_start(4'b0001, 4'd0, 1'b0, t0);
    repeat (10) @(negedge clk);
    checks++; if (busy_cnt != 0 || soc_cyc.size() != 0) begin errors++; $display("FAIL dis_start_ignored got busy_cycles=%0d soc=%0d want 0/0", busy_cnt, soc_cyc.size()); end
    enable = 1'b1;
    clear_logs();
    pulse_start(4'b0000, 4'd0, 1'b0, t0);
    repeat (10) @(negedge clk);
    checks++; if (busy_cnt != 0 || soc_cyc.size() != 0 || sd_cnt != 0) begin
      errors++; $display("FAIL zero_mask got busy_cycles=%0d soc=%0d done=%0d want 0/0/0", busy_cnt, soc_cyc.size(), sd_cnt);
    end
    $display("test_disable done");
  endtask

`ifdef ADC_SAR_SCAN_AVG_EN
  task automatic test_avg();
    int t0;
    bit to;
    fixed_q = '{10, 11, 12, 13};
    clear_logs();
    pulse_start(4'b0001, 4'd1, 1'b0, t0);
    wait_idle(500, to);
    checks++; if (to || st_ch.size() != 1) begin errors++; $display("FAIL avg_strobes got to=%0d strobes=%0d want 0/1", to, st_ch.size()); end
    else begin
      checks++; if (st_data[0] != 11 || st_ch[0] != 0) begin errors++; $display("FAIL avg_result got ch=%0d data=%0d want 0/11", st_ch[0], st_data[0]); end
    end
    checks++; if (soc_cyc.size() != 4) begin errors++; $display("FAIL avg_soc_count got %0d want 4", soc_cyc.size()); end
    $display("test_avg done");
  endtask
`endif

  initial begin
    test_reset();
    test_mask_scans();
    test_single_ch1();
    test_continuous();
    test_reset_mid();
    test_disable();
`ifdef ADC_SAR_SCAN_AVG_EN
    test_avg();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
